attention_softmax: RTL

//  Row-wise softmax over the attention score tensor A (L,N,L) from the score stage.

---
 rtl/attention_softmax.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/attention_softmax.sv
// attention_softmax
//   Row-wise softmax over the attention score tensor A (L,N,L). Each row is
//   processed one element per cycle: find the row max, look up exp(-(m-x))
//   in a 16-entry table while summing, then normalise every element with a
//   DW-cycle restoring divide. The finished tensor is published on A_out in
//   a single update at the end of the run.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; aborts any run in progress
//   start      begin a run (only looked at while idle)
//   A_in       signed scores, Q(DW-FRAC_BITS).FRAC_BITS, flat bus, element
//              k = (l*N+n)*L+j sits at bit (L*N*L-1-k)*DW
//   A_out      unsigned weights Q1.(DW-1), same layout as A_in
//   done       one-cycle pulse when A_out has just been updated
//   out_valid  A_out holds a complete result (cleared by the next start)
//   busy       high from the cycle after start acceptance through done
module attention_softmax #(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 8,
  parameter int N          = 1,
  parameter int FRAC_BITS  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [DATA_WIDTH*L*N*L-1:0]  A_in,
  output logic [DATA_WIDTH*L*N*L-1:0]  A_out,
  output logic                         done,
  output logic                         out_valid,
  output logic                         busy
);

  localparam int DW  = DATA_WIDTH;
  localparam int TOT = L * N * L;
  // Row sum of up to L entries of a 16-bit table.
  localparam int SW  = 16 + $clog2(L);
  localparam int JW  = (L > 1) ? $clog2(L) : 1;
  localparam int KW  = (DW > 1) ? $clog2(DW) : 1;
  localparam int EW  = (TOT > 1) ? $clog2(TOT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAX,
    ST_EXP,
    ST_DIV,
    ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic signed [DW-1:0]  a_q [TOT];
  logic signed [DW-1:0]  a_d [TOT];
  logic [DW-1:0]         p_q [TOT];
  logic [DW-1:0]         p_d [TOT];
  logic [15:0]           e_q [L];
  logic [15:0]           e_d [L];
  logic signed [DW-1:0]  m_q, m_d;
  logic [SW-1:0]         s_q, s_d;
  logic [SW-1:0]         rem_q, rem_d;
  logic [DW-1:0]         low_q, low_d;
  logic [DW-1:0]         quo_q, quo_d;
  logic [JW-1:0]         j_q, j_d;
  logic [KW-1:0]         k_q, k_d;
  logic [EW-1:0]         row_q, row_d;
  logic [TOT*DW-1:0]     aout_q, aout_d;
  logic                  valid_q, valid_d;

  // Element datapath helpers
  logic [EW-1:0]         elemIdx;
  logic signed [DW-1:0]  curX;
  logic signed [DW:0]    diff;
  logic signed [DW:0]    diffShift;
  logic [3:0]            lutIdx;
  logic [15:0]           expVal;
  logic [SW-1:0]         curRem;
  logic [DW-1:0]         curLow;
  logic [DW-1:0]         curQuo;
  logic [SW:0]           trial;
  logic                  qBit;
  logic [SW-1:0]         remNext;
  logic [DW-1:0]         quoNext;
  logic [DW-1:0]         pVal;

  logic lastJ, lastK, lastRow;

  function automatic logic [15:0] lutExp(input logic [3:0] d);
    logic [15:0] v;
    case (d)
      4'd0:    v = 16'd65535;
      4'd1:    v = 16'd24109;
      4'd2:    v = 16'd8869;
      4'd3:    v = 16'd3262;
      4'd4:    v = 16'd1200;
      4'd5:    v = 16'd441;
      4'd6:    v = 16'd162;
      4'd7:    v = 16'd59;
      4'd8:    v = 16'd21;
      4'd9:    v = 16'd8;
      4'd10:   v = 16'd2;
      4'd11:   v = 16'd1;
      default: v = 16'd0;
    endcase
    return v;
  endfunction

  // Current element and its table lookup. The difference is taken one bit
  // wider than the scores so that max-min over the full signed range cannot
  // wrap; it is never negative once the row max is known.
  always_comb begin
    elemIdx   = row_q + EW'(j_q);
    curX      = a_q[elemIdx];
    diff      = {m_q[DW-1], m_q} - {curX[DW-1], curX};
    diffShift = diff >>> FRAC_BITS;
    lutIdx    = (|diffShift[DW:4]) ? 4'hF : diffShift[3:0];
    expVal    = lutExp(lutIdx);
  end

  // One restoring-divide step of e_j * 2^(DW-1) / S. The dividend's upper
  // part (e_j >> 1) is already below S, so DW steps yield the full quotient;
  // on the first step the remainder and the low dividend bits are seeded
  // straight from e_j. The quotient can only reach 2^(DW-1) when e_j == S,
  // which is clamped to the largest representable weight.
  always_comb begin
    curRem  = (k_q == '0) ? SW'(e_q[j_q] >> 1) : rem_q;
    curLow  = (k_q == '0) ? {e_q[j_q][0], {(DW-1){1'b0}}} : low_q;
    curQuo  = (k_q == '0) ? '0 : quo_q;
    trial   = {curRem, curLow[DW-1]};
    if (trial >= {1'b0, s_q}) begin
      qBit    = 1'b1;
      remNext = SW'(trial - {1'b0, s_q});
    end else begin
      qBit    = 1'b0;
      remNext = SW'(trial);
    end
    quoNext = {curQuo[DW-2:0], qBit};
    pVal    = quoNext[DW-1] ? {1'b0, {(DW-1){1'b1}}} : quoNext;
  end

  assign lastJ   = (j_q == JW'(L - 1));
  assign lastK   = (k_q == KW'(DW - 1));
  assign lastRow = (row_q == EW'(TOT - L));

  // Sequencer: per row a max pass, an exp/sum pass and a divide pass, then a
  // single publish of all weights when the last element of the last row is
  // finished, so A_out is already complete during the done cycle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    p_d     = p_q;
    e_d     = e_q;
    m_d     = m_q;
    s_d     = s_q;
    rem_d   = rem_q;
    low_d   = low_q;
    quo_d   = quo_q;
    j_d     = j_q;
    k_d     = k_q;
    row_d   = row_q;
    aout_d  = aout_q;
    valid_d = valid_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          valid_d = 1'b0;
        end
      end

      ST_LOAD: begin
        for (int i = 0; i < TOT; i++) begin
          a_d[i] = A_in[(TOT-1-i)*DW +: DW];
        end
        j_d     = '0;
        row_d   = '0;
        state_d = ST_MAX;
      end

      ST_MAX: begin
        if ((j_q == '0) || (curX > m_q)) begin
          m_d = curX;
        end
        if (lastJ) begin
          j_d     = '0;
          s_d     = '0;
          state_d = ST_EXP;
        end else begin
          j_d = j_q + 1'b1;
        end
      end

      ST_EXP: begin
        e_d[j_q] = expVal;
        s_d      = s_q + SW'(expVal);
        if (lastJ) begin
          j_d     = '0;
          k_d     = '0;
          state_d = ST_DIV;
        end else begin
          j_d = j_q + 1'b1;
        end
      end

      ST_DIV: begin
        rem_d = remNext;
        low_d = curLow << 1;
        quo_d = quoNext;
        k_d   = k_q + 1'b1;
        if (lastK) begin
          k_d          = '0;
          p_d[elemIdx] = pVal;
          if (lastJ) begin
            j_d = '0;
            if (lastRow) begin
              for (int i = 0; i < TOT; i++) begin
                aout_d[(TOT-1-i)*DW +: DW] = p_d[i];
              end
              valid_d = 1'b1;
              state_d = ST_DONE;
            end else begin
              row_d   = row_q + EW'(L);
              state_d = ST_MAX;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops everything, including any
  // partially computed weights.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < TOT; i++) begin
        a_q[i] <= '0;
        p_q[i] <= '0;
      end
      for (int i = 0; i < L; i++) begin
        e_q[i] <= '0;
      end
      m_q     <= '0;
      s_q     <= '0;
      rem_q   <= '0;
      low_q   <= '0;
      quo_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      row_q   <= '0;
      aout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      p_q     <= p_d;
      e_q     <= e_d;
      m_q     <= m_d;
      s_q     <= s_d;
      rem_q   <= rem_d;
      low_q   <= low_d;
      quo_q   <= quo_d;
      j_q     <= j_d;
      k_q     <= k_d;
      row_q   <= row_d;
      aout_q  <= aout_d;
      valid_q <= valid_d;
    end
  end

  assign A_out     = aout_q;
  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = valid_q;

endmodule
